ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 4, RAM address width; DATA_W, 8, RAM data width.
REQ-002 Port clk_in  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst_n_in  input  1  asynchronous, active-low reset.
REQ-004 Ports req_a_in / req_b_in  input  1  requester A/B access request, held until granted.
REQ-005 Ports we_a_in / we_b_in  input  1  1 = write, 0 = read; valid while req high.
REQ-006 Ports addr_a_in / addr_b_in  input  ADDR_W  target location.
REQ-007 Ports wdata_a_in / wdata_b_in  input  DATA_W  write data.
REQ-008 Ports gnt_a_out / gnt_b_out  output  1  one-cycle pulse: request accepted.
REQ-009 Ports rvalid_a_out / rvalid_b_out  output  1  one-cycle pulse: rdata valid.
REQ-010 Ports rdata_a_out / rdata_b_out  output  DATA_W  read data, held until next read by that requester.
REQ-011 Port ram_write_out  output  1  RAM write strobe.
REQ-012 Port ram_enable_out  output  1  RAM read enable.
REQ-013 Port ram_addr_out  output  ADDR_W  RAM address.
REQ-014 Port ram_data_io  inout  DATA_W  shared single-port RAM data bus.

Function
REQ-015 The FSM SHALL have two states: IDLE (arbitrate) and ACC (drive RAM).
REQ-016 In IDLE, if any req is high at a rising edge, the winner's we/addr/wdata SHALL be latched, its gnt pulses high for the following cycle, and the state SHALL go to ACC.
REQ-017 In IDLE with no req, the FSM SHALL stay in IDLE with all gnt low.
REQ-018 Arbitration SHALL be round-robin: a sole requester always wins; on simultaneous requests, the requester not granted last wins.
REQ-019 The last-granted pointer SHALL update only on a grant.
REQ-020 In ACC for a latched write: ram_write_out=1, ram_enable_out=0, ram_addr_out=latched addr, ram_data_io driven with latched wdata.
REQ-021 In ACC for a latched read: ram_write_out=0, ram_enable_out=1, ram_addr_out=latched addr, ram_data_io high-Z.
REQ-022 At the rising edge ending ACC on a read, ram_data_io SHALL be captured into the winner's rdata, and its rvalid SHALL pulse for one cycle; the state SHALL return to IDLE.
REQ-023 On a write, no rvalid SHALL pulse; the state SHALL return to IDLE.
REQ-024 Latency SHALL be: req sampled at edge N -> gnt cycle N..N+1 (ACC) -> rvalid cycle N+1..N+2.
REQ-025 Throughput SHALL be one access per 2 cycles; a continuously held req SHALL be regranted on the edge ending ACC+IDLE.
REQ-026 Outside ACC: ram_write_out=0, ram_enable_out=0, ram_data_io high-Z, ram_addr_out holds its last value.
REQ-027 ram_write_out and ram_enable_out SHALL never be high together.
REQ-028 The block SHALL drive ram_data_io only while in ACC with a latched write.
REQ-029 Request inputs changing after gnt SHALL NOT affect the access in flight.
REQ-030 Addresses 0 and 2^ADDR_W-1 SHALL need no special handling; there is no address wrap.

Reset
REQ-031 Asserting rst_n_in low SHALL immediately force state=IDLE, pointer=B-last (A wins first tie), all gnt/rvalid=0, rdata=0, ram_write_out=0, ram_enable_out=0, ram_addr_out=0, and ram_data_io high-Z.
REQ-032 Reset during ACC SHALL abort the access: no rvalid; on an aborted write, the target location's content is unspecified.
REQ-033 The first grant SHALL be possible at the first rising edge after reset release.

Structure
REQ-034 Package ram_arb_pkg SHALL hold ADDR_W/DATA_W defaults and the state encoding (IDLE, ACC).
REQ-035 Sub-module rr_arb2 SHALL contain the 2-way round-robin arbiter: inputs are the reqs, an enable, clk_in and rst_n_in; the output is a one-hot winner; it owns the pointer.
REQ-036 The RAM SHALL be instantiated outside this block and connected via the ram_* ports.

Verification
REQ-037 Scenario: A writes 0x5A to addr 3 (req_a only) -> gnt_a 1 cycle; next cycle write=1, enable=0, addr=3, bus=0x5A; no rvalid.
REQ-038 Scenario: A reads addr 3 after REQ-037 -> enable=1, write=0, bus driven by RAM; rdata_a=0x5A with a one-cycle rvalid_a, 2 cycles after req sampled.
REQ-039 Scenario: A and B both request reads continuously from reset -> grant order A,B,A,B; gnt pulses every 2 cycles.
REQ-040 Scenario: B writes 0xFF to addr 15 and 0x01 to addr 0, then reads both -> 0xFF and 0x01 returned; the bus is never driven by both sides (no X).
REQ-041 Scenario: rst_n_in low mid-ACC of a read -> write/enable drop to 0 immediately, bus Z, no rvalid; after release, a held req_b is granted on the first edge.
REQ-042 The bench SHALL assert throughout that ram_write_out and ram_enable_out are never both high, and that at most one gnt is high.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared defaults and FSM encoding for the two-requester single-port RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; win_out is one-hot {B, A} and the pointer moves only on a grant.
module rr_arb2 (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       req_a_in,
    input  logic       req_b_in,
    input  logic       en_in,
    output logic [1:0] win_out
);

    logic last_a_q;
    logic last_a_d;

    always_comb begin
        win_out = 2'b00;
        if (req_a_in && req_b_in) begin
            win_out = last_a_q ? 2'b10 : 2'b01;
        end else if (req_a_in) begin
            win_out = 2'b01;
        end else if (req_b_in) begin
            win_out = 2'b10;
        end
    end

    always_comb begin
        last_a_d = last_a_q;
        if (en_in && (win_out != 2'b00)) begin
            last_a_d = win_out[0];
        end
    end

    // Reset leaves B as last-granted so A wins the first tie.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_a_q <= 1'b0;
        end else begin
            last_a_q <= last_a_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto an external single-port RAM: one access per two cycles
// (IDLE arbitrates and latches the winner, ACC drives the RAM and collects read data).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_a_in,
    input  logic              req_b_in,
    input  logic              we_a_in,
    input  logic              we_b_in,
    input  logic [ADDR_W-1:0] addr_a_in,
    input  logic [ADDR_W-1:0] addr_b_in,
    input  logic [DATA_W-1:0] wdata_a_in,
    input  logic [DATA_W-1:0] wdata_b_in,
    output logic              gnt_a_out,
    output logic              gnt_b_out,
    output logic              rvalid_a_out,
    output logic              rvalid_b_out,
    output logic [DATA_W-1:0] rdata_a_out,
    output logic [DATA_W-1:0] rdata_b_out,
    output logic              ram_write_out,
    output logic              ram_enable_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    inout  wire  [DATA_W-1:0] ram_data_io
);

    state_e            state_q, state_d;
    logic [1:0]        win;
    logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic              we_q, we_d;
    logic              owner_b_q, owner_b_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    rr_arb2 u_arb (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .req_a_in (req_a_in),
        .req_b_in (req_b_in),
        .en_in    (state_q == IDLE),
        .win_out  (win)
    );

    always_comb begin
        state_d    = state_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        we_d       = we_q;
        owner_b_d  = owner_b_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (win[0]) begin
                    we_d      = we_a_in;
                    addr_d    = addr_a_in;
                    wdata_d   = wdata_a_in;
                    owner_b_d = 1'b0;
                    gnt_a_d   = 1'b1;
                    state_d   = ACC;
                end else if (win[1]) begin
                    we_d      = we_b_in;
                    addr_d    = addr_b_in;
                    wdata_d   = wdata_b_in;
                    owner_b_d = 1'b1;
                    gnt_b_d   = 1'b1;
                    state_d   = ACC;
                end
            end
            ACC: begin
                state_d = IDLE;
                if (!we_q) begin
                    if (owner_b_q) begin
                        rdata_b_d  = ram_data_io;
                        rvalid_b_d = 1'b1;
                    end else begin
                        rdata_a_d  = ram_data_io;
                        rvalid_a_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            we_q       <= 1'b0;
            owner_b_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            we_q       <= we_d;
            owner_b_q  <= owner_b_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Strobes decode straight from the state so an asynchronous reset drops them at once.
    assign ram_write_out  = (state_q == ACC) && we_q;
    assign ram_enable_out = (state_q == ACC) && !we_q;
    assign ram_addr_out   = addr_q;
    assign ram_data_io    = ram_write_out ? wdata_q : {DATA_W{1'bz}};

    assign gnt_a_out    = gnt_a_q;
    assign gnt_b_out    = gnt_b_q;
    assign rvalid_a_out = rvalid_a_q;
    assign rvalid_b_out = rvalid_b_q;
    assign rdata_a_out  = rdata_a_q;
    assign rdata_b_out  = rdata_b_q;

endmodule
